// File: rtl/alarm_set_ctrl.sv
// Alarm programming front-end: edits h/m/s from button pulses, then replays them
// to the clock block as a set_alarm-framed strobe sequence, and raises start.
module alarm_set_ctrl #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ok,
  output logic       set_alarm,
  output logic       set_hours,
  output logic       set_mins,
  output logic       set_secs,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_mins,
  output logic [5:0] alarm_secs,
  output logic       start,
  output logic [1:0] edit_field,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, EDIT_H, EDIT_M, EDIT_S, SETUP, STB_H, STB_M, STB_S, GAP, RUN
  } state_t;

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  state_t     gap_nxt_q, gap_nxt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [4:0] edit_h_q, edit_h_d;
  logic [5:0] edit_m_q, edit_m_d;
  logic [5:0] edit_s_q, edit_s_d;

  logic       set_alarm_q, set_alarm_d;
  logic       set_hours_q, set_hours_d;
  logic       set_mins_q, set_mins_d;
  logic       set_secs_q, set_secs_d;
  logic [4:0] alarm_hours_q, alarm_hours_d;
  logic [5:0] alarm_mins_q, alarm_mins_d;
  logic [5:0] alarm_secs_q, alarm_secs_d;
  logic       start_q, start_d;
  logic [1:0] edit_field_q, edit_field_d;
  logic       commit;

  always_comb begin
    state_d   = state_q;
    gap_nxt_d = gap_nxt_q;
    gap_cnt_d = gap_cnt_q;
    edit_h_d  = edit_h_q;
    edit_m_d  = edit_m_q;
    edit_s_d  = edit_s_q;

    case (state_q)
      IDLE, RUN: begin
        if (btn_mode) begin
          state_d  = EDIT_H;
          edit_h_d = alarm_hours_q;
          edit_m_d = alarm_mins_q;
          edit_s_d = alarm_secs_q;
        end
      end
      EDIT_H, EDIT_M, EDIT_S: begin
        if (btn_ok) begin
          state_d = SETUP;
        end else if (btn_mode) begin
          state_d = (state_q == EDIT_H) ? EDIT_M :
                    (state_q == EDIT_M) ? EDIT_S : EDIT_H;
        end else if (btn_inc) begin
          case (state_q)
            EDIT_H:  edit_h_d = (edit_h_q == 5'd23) ? 5'd0 : edit_h_q + 5'd1;
            EDIT_M:  edit_m_d = (edit_m_q == 6'd59) ? 6'd0 : edit_m_q + 6'd1;
            default: edit_s_d = (edit_s_q == 6'd59) ? 6'd0 : edit_s_q + 6'd1;
          endcase
        end
      end
      SETUP: state_d = STB_H;
      STB_H, STB_M, STB_S: begin
        // gap_nxt remembers which strobe (or RUN) the gap hands over to
        gap_nxt_d = (state_q == STB_H) ? STB_M : (state_q == STB_M) ? STB_S : RUN;
        gap_cnt_d = GAP_LOAD;
        state_d   = (GAP_CYCLES == 0) ? gap_nxt_d : GAP;
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) state_d = gap_nxt_q;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    commit        = (state_d == SETUP) || (state_d == STB_H) || (state_d == STB_M) ||
                    (state_d == STB_S) || (state_d == GAP);
    set_alarm_d   = commit;
    set_hours_d   = (state_d == STB_H);
    set_mins_d    = (state_d == STB_M);
    set_secs_d    = (state_d == STB_S);
    alarm_hours_d = set_hours_d ? edit_h_q : alarm_hours_q;
    alarm_mins_d  = set_mins_d  ? edit_m_q : alarm_mins_q;
    alarm_secs_d  = set_secs_d  ? edit_s_q : alarm_secs_q;
    start_d       = start_q || (state_d == RUN);
    edit_field_d  = (state_d == EDIT_H) ? 2'd1 :
                    (state_d == EDIT_M) ? 2'd2 :
                    (state_d == EDIT_S) ? 2'd3 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gap_nxt_q     <= IDLE;
      gap_cnt_q     <= 4'd0;
      edit_h_q      <= 5'd0;
      edit_m_q      <= 6'd0;
      edit_s_q      <= 6'd0;
      set_alarm_q   <= 1'b0;
      set_hours_q   <= 1'b0;
      set_mins_q    <= 1'b0;
      set_secs_q    <= 1'b0;
      alarm_hours_q <= 5'd0;
      alarm_mins_q  <= 6'd0;
      alarm_secs_q  <= 6'd0;
      start_q       <= 1'b0;
      edit_field_q  <= 2'd0;
    end else begin
      state_q       <= state_d;
      gap_nxt_q     <= gap_nxt_d;
      gap_cnt_q     <= gap_cnt_d;
      edit_h_q      <= edit_h_d;
      edit_m_q      <= edit_m_d;
      edit_s_q      <= edit_s_d;
      set_alarm_q   <= set_alarm_d;
      set_hours_q   <= set_hours_d;
      set_mins_q    <= set_mins_d;
      set_secs_q    <= set_secs_d;
      alarm_hours_q <= alarm_hours_d;
      alarm_mins_q  <= alarm_mins_d;
      alarm_secs_q  <= alarm_secs_d;
      start_q       <= start_d;
      edit_field_q  <= edit_field_d;
    end
  end

  assign set_alarm   = set_alarm_q;
  assign busy        = set_alarm_q;
  assign set_hours   = set_hours_q;
  assign set_mins    = set_mins_q;
  assign set_secs    = set_secs_q;
  assign alarm_hours = alarm_hours_q;
  assign alarm_mins  = alarm_mins_q;
  assign alarm_secs  = alarm_secs_q;
  assign start       = start_q;
  assign edit_field  = edit_field_q;

endmodule
